// File: rtl/operand2_imm_encoder_if.sv
// Request/result bundle for the operand-2 immediate encoder.
// The master issues start/value and receives the encoded field; the slave is the encoder.
interface operand2_imm_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic        inverted;
  logic [11:0] imm12;

  modport master (
    output start, value,
    input  busy, done, valid, inverted, imm12
  );

  modport slave (
    input  start, value,
    output busy, done, valid, inverted, imm12
  );
endinterface

// File: rtl/operand2_imm_encoder.sv
// Multi-cycle search for {rot, imm8} whose ROR(imm8, 2*rot) expansion reproduces a 32-bit constant,
// optionally through its complement (MOV/MVN substitution). One candidate is tested per cycle.
module operand2_imm_encoder #(
  parameter bit TRY_INVERT = 1'b1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  operand2_imm_encoder_if.slave  bus_s
);

  localparam logic [4:0] LAST_K = TRY_INVERT ? 5'd31 : 5'd15;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t      state_q;
  logic [4:0]  k_q;
  logic [31:0] v_q;
  logic        done_q;
  logic        valid_q;
  logic        inverted_q;
  logic [11:0] imm12_q;

  logic [31:0] cand;
  logic [4:0]  rot_amt;
  logic [63:0] dbl;
  logic [31:0] rol_val;
  logic        hit;

  // k[4] selects the complemented operand; the upper half of {c,c}<<n is ROL(c, n).
  always_comb begin
    cand    = k_q[4] ? ~v_q : v_q;
    rot_amt = {k_q[3:0], 1'b0};
    dbl     = {cand, cand} << rot_amt;
    rol_val = dbl[63:32];
    hit     = (rol_val[31:8] == 24'd0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      k_q        <= 5'd0;
      v_q        <= 32'd0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      inverted_q <= 1'b0;
      imm12_q    <= 12'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_s.start) begin
            v_q     <= bus_s.value;
            k_q     <= 5'd0;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            valid_q    <= 1'b1;
            inverted_q <= k_q[4];
            imm12_q    <= {k_q[3:0], rol_val[7:0]};
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end else if (k_q == LAST_K) begin
            valid_q    <= 1'b0;
            inverted_q <= 1'b0;
            imm12_q    <= 12'd0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end else begin
            k_q <= k_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_s.busy     = (state_q == SEARCH);
  assign bus_s.done     = done_q;
  assign bus_s.valid    = valid_q;
  assign bus_s.inverted = inverted_q;
  assign bus_s.imm12    = imm12_q;

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// Self-checking bench for operand2_imm_encoder: TRY_INVERT=1 and TRY_INVERT=0 instances,
// directed scenarios plus a random sweep against a reference search model via a scoreboard.
module tb_operand2_imm_encoder;

  typedef struct {
    logic [13:0] res;   // {valid, inverted, imm12}
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand2_imm_encoder_if bus0 ();
  operand2_imm_encoder_if bus1 ();

  operand2_imm_encoder #(.TRY_INVERT(1'b1)) dut0 (.clk_i(clk), .rst_i(rst), .bus_s(bus0.slave));
  operand2_imm_encoder #(.TRY_INVERT(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .bus_s(bus1.slave));

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic exp_t mk(input logic v, input logic inv, input logic [11:0] imm, input int lat);
    exp_t e;
    e.res = {v, inv, imm};
    e.lat = lat;
    return e;
  endfunction

  // Reference: first (operand, rot) whose 8-bit window re-expands exactly to the operand.
  function automatic exp_t model(input logic [31:0] v, input bit try_inv);
    exp_t e;
    logic [31:0] c, t;
    logic [7:0] imm8;
    for (int i = 0; i < 2; i++) begin
      if (i == 1 && !try_inv) break;
      c = (i == 1) ? ~v : v;
      for (int r = 0; r < 16; r++) begin
        t = ror32(c, (32 - 2 * r) % 32);
        imm8 = t[7:0];
        if (ror32({24'd0, imm8}, 2 * r) == c) begin
          e.res = {1'b1, 1'(i), 4'(r), imm8};
          e.lat = i * 16 + r + 1;
          return e;
        end
      end
    end
    e.res = '0;
    e.lat = try_inv ? 32 : 16;
    return e;
  endfunction

  function automatic logic [13:0] obs(input int sel);
    if (sel == 0) return {bus0.valid, bus0.inverted, bus0.imm12};
    return {bus1.valid, bus1.inverted, bus1.imm12};
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction

  // Drive Start for one cycle from a negedge; returns on the negedge after the accepting edge.
  task automatic launch(input int sel, input logic [31:0] v, input exp_t e, input bit push);
    if (push) sb_q.push_back(e);
    if (sel == 0) begin bus0.start = 1'b1; bus0.value = v; end
    else          begin bus1.start = 1'b1; bus1.value = v; end
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int pre, output int cyc);
    cyc = -1;
    for (int i = pre + 1; i <= 64; i++) begin
      @(negedge clk);
      if (done_of(sel)) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus0.start = 1'b0; bus0.value = '0;
    bus1.start = 1'b0; bus1.value = '0;
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({bus0.busy, bus0.done, obs(0)} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_dut0: got %h want 0000", {bus0.busy, bus0.done, obs(0)});
    end
    n_cmp++;
    if ({bus1.busy, bus1.done, obs(1)} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_dut1: got %h want 0000", {bus1.busy, bus1.done, obs(1)});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    int cyc;
    launch(0, 32'h0000_00FF, mk(1'b1, 1'b0, 12'h0FF, 1), 1'b1);
    n_cmp++;
    if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_on: got %b want 1", bus0.busy); end
    wait_done(0, 0, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL basic_result: got %h want %h", obs(0), e.res); end
    n_cmp++;
    if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_off: got %b want 0", bus0.busy); end
    @(negedge clk);
    n_cmp++;
    if ({bus0.done, obs(0)} !== {1'b0, e.res}) begin
      n_err++;
      $display("FAIL basic_pulse_hold: got %h want %h", {bus0.done, obs(0)}, {1'b0, e.res});
    end
  endtask

  task automatic test_rotations();
    exp_t e;
    int cyc;
    launch(0, 32'hFF00_0000, mk(1'b1, 1'b0, 12'h4FF, 5), 1'b1);
    bus0.value = 32'h1234_5678;
    wait_done(0, 0, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL rot4_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL rot4_result: got %h want %h", obs(0), e.res); end
    @(negedge clk);
    launch(0, 32'h0000_03FC, mk(1'b1, 1'b0, 12'hFFF, 16), 1'b1);
    wait_done(0, 0, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL rot15_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL rot15_result: got %h want %h", obs(0), e.res); end
    @(negedge clk);
  endtask

  task automatic test_invert();
    exp_t e;
    int cyc;
    launch(0, 32'hFFFF_FF00, mk(1'b1, 1'b1, 12'h0FF, 17), 1'b1);
    wait_done(0, 0, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL inv_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL inv_result: got %h want %h", obs(0), e.res); end
    @(negedge clk);
    launch(1, 32'hFFFF_FF00, mk(1'b0, 1'b0, 12'h000, 16), 1'b1);
    wait_done(1, 0, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL noinv_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(1) !== e.res) begin n_err++; $display("FAIL noinv_result: got %h want %h", obs(1), e.res); end
    @(negedge clk);
  endtask

  task automatic test_nomatch();
    exp_t e;
    int cyc;
    logic [13:0] prev;
    prev = obs(0);
    launch(0, 32'h1234_5678, mk(1'b0, 1'b0, 12'h000, 32), 1'b1);
    n_cmp++;
    if (obs(0) !== prev) begin n_err++; $display("FAIL hold_on_accept: got %h want %h", obs(0), prev); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({bus0.busy, obs(0)} !== {1'b1, prev}) begin
      n_err++;
      $display("FAIL hold_mid_search: got %h want %h", {bus0.busy, obs(0)}, {1'b1, prev});
    end
    wait_done(0, 20, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL nomatch_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL nomatch_result: got %h want %h", obs(0), e.res); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    launch(0, 32'h1234_5678, mk(1'b0, 1'b0, 12'h000, 32), 1'b1);
    cyc = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      bus0.start = 1'b0;
      if (done_of(0)) begin
        cyc = i;
        break;
      end
      if (i == 3 || i == 10) begin
        bus0.start = 1'b1;
        bus0.value = 32'h0000_00FF;
      end
    end
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL ignore_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL ignore_result: got %h want %h", obs(0), e.res); end
    launch(0, 32'h0000_00FF, mk(1'b1, 1'b0, 12'h0FF, 1), 1'b1);
    n_cmp++;
    if ({bus0.busy, bus0.done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept: got busy/done %b want 10", {bus0.busy, bus0.done});
    end
    wait_done(0, 0, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL b2b_result: got %h want %h", obs(0), e.res); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc;
    logic saw_done;
    launch(0, 32'h1234_5678, mk(1'b0, 1'b0, 12'h000, 32), 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus0.busy, bus0.done, obs(0)} !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0000", {bus0.busy, bus0.done, obs(0)});
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | bus0.done | bus0.busy;
    end
    rst = 1'b0;
    @(negedge clk);
    saw_done = saw_done | bus0.done | bus0.busy;
    n_cmp++;
    if (saw_done !== 1'b0) begin n_err++; $display("FAIL reset_no_done: got %b want 0", saw_done); end
    launch(0, 32'hFF00_0000, mk(1'b1, 1'b0, 12'h4FF, 5), 1'b1);
    wait_done(0, 0, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL post_reset_latency: got %0d want %0d", cyc, e.lat); end
    n_cmp++;
    if (obs(0) !== e.res) begin n_err++; $display("FAIL post_reset_result: got %h want %h", obs(0), e.res); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    exp_t e;
    int cyc, sel;
    logic [31:0] v, recon;
    logic [13:0] o;
    for (int n = 0; n < 24; n++) begin
      sel = (n % 3 == 2) ? 1 : 0;
      case ($urandom_range(0, 2))
        0:       v = ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
        1:       v = ~ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
        default: v = $urandom;
      endcase
      launch(sel, v, model(v, sel == 0), 1'b1);
      wait_done(sel, 0, cyc);
      e = sb_q.pop_front();
      o = obs(sel);
      n_cmp++;
      if (cyc !== e.lat) begin
        n_err++;
        $display("FAIL sweep_latency v=%h dut%0d: got %0d want %0d", v, sel, cyc, e.lat);
      end
      n_cmp++;
      if (o !== e.res) begin
        n_err++;
        $display("FAIL sweep_result v=%h dut%0d: got %h want %h", v, sel, o, e.res);
      end
      if (o[13]) begin
        recon = ror32({24'd0, o[7:0]}, 2 * int'(o[11:8]));
        if (o[12]) recon = ~recon;
        n_cmp++;
        if (recon !== v) begin
          n_err++;
          $display("FAIL sweep_identity dut%0d: got %h want %h", sel, recon, v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotations();
    test_invert();
    test_nomatch();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
